// File: rtl/crc_engine.sv
// Serial CRC-5 / CRC-8 generate-and-check engine, one message bit per clk_2 cycle.
// Optional saturating error counter output enabled by defining CRC_ENGINE_ERR_CNT_EN.
module crc_engine #(
  parameter int pDATA_WIDTH = 60
) (
  input  logic                   clk_2,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_mode,
  input  logic                   in_crc,
  input  logic [pDATA_WIDTH-1:0] in_message,
  output logic                   busy,
  output logic                   out_valid,
  output logic [pDATA_WIDTH-1:0] out_message,
  output logic                   out_err
`ifdef CRC_ENGINE_ERR_CNT_EN
  ,
  output logic [7:0]             err_cnt
`endif
);

  localparam int W  = pDATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state;
  state_t          state_next;
  logic [W-1:0]    shift_reg;
  logic [W-1:0]    msg_reg;
  logic [W-1:0]    low_mask;
  logic [W-1:0]    load_word;
  logic            mode_reg;
  logic            crc_reg;
  logic [7:0]      rem;
  logic [7:0]      rem_next;
  logic [CW-1:0]   bit_cnt;
  logic            accept;
  logic            last_bit;

  assign accept   = (state == IDLE) && in_valid;
  assign last_bit = (bit_cnt == CW'(W - 1));

  // Generate mode clears the slot the CRC will later occupy before dividing.
  always_comb begin
    low_mask  = in_crc ? W'(8'hFF) : W'(5'h1F);
    load_word = in_mode ? in_message : (in_message & ~low_mask);
  end

  // One long-division step; CRC-5 keeps rem[7:5] at zero.
  always_comb begin
    rem_next = '0;
    if (crc_reg) begin
      rem_next = {rem[6:0], shift_reg[W-1]} ^ (rem[7] ? 8'h07 : 8'h00);
    end else begin
      rem_next = {3'b000, rem[3:0], shift_reg[W-1]} ^ (rem[4] ? 8'h05 : 8'h00);
    end
  end

  always_ff @(posedge clk_2 or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk_2 or posedge rst) begin
    if (rst) begin
      shift_reg   <= '0;
      msg_reg     <= '0;
      mode_reg    <= 1'b0;
      crc_reg     <= 1'b0;
      rem         <= '0;
      bit_cnt     <= '0;
      out_valid   <= 1'b0;
      out_message <= '0;
      out_err     <= 1'b0;
    end else begin
      out_valid <= (state == DONE);
      if (accept) begin
        shift_reg <= load_word;
        msg_reg   <= load_word;
        mode_reg  <= in_mode;
        crc_reg   <= in_crc;
        rem       <= '0;
        bit_cnt   <= '0;
      end
      if (state == SHIFT) begin
        shift_reg <= {shift_reg[W-2:0], 1'b0};
        rem       <= rem_next;
        bit_cnt   <= bit_cnt + 1'b1;
      end
      // The masked low bits of msg_reg are zero, so OR-ing inserts the CRC.
      if (state == DONE) begin
        out_message <= mode_reg ? msg_reg : (msg_reg | W'(rem));
        out_err     <= mode_reg && (rem != 8'h00);
      end
    end
  end

`ifdef CRC_ENGINE_ERR_CNT_EN
  always_ff @(posedge clk_2 or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if ((state == DONE) && mode_reg && (rem != 8'h00) && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_crc_engine.sv
// Self-checking bench for crc_engine: vector table plus scoreboard, with
// hand-written busy-drop, mid-word reset and (optional) counter saturation runs.
module tb_crc_engine;

  localparam int W = 60;

  logic         clk_2 = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_mode;
  logic         in_crc;
  logic [W-1:0] in_message;
  logic         busy;
  logic         out_valid;
  logic [W-1:0] out_message;
  logic         out_err;
`ifdef CRC_ENGINE_ERR_CNT_EN
  logic [7:0]   err_cnt;
`endif

  crc_engine #(.pDATA_WIDTH(W)) dut (
    .clk_2       (clk_2),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_mode     (in_mode),
    .in_crc      (in_crc),
    .in_message  (in_message),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_message (out_message),
    .out_err     (out_err)
`ifdef CRC_ENGINE_ERR_CNT_EN
    ,
    .err_cnt     (err_cnt)
`endif
  );

  always #5 clk_2 = ~clk_2;

  typedef struct {
    logic         mode;
    logic         crc;
    logic [W-1:0] msg;
    logic [W-1:0] exp_msg;
    logic         exp_err;
  } vec_t;

  typedef struct {
    logic [W-1:0] msg;
    logic         err;
    int           t_acc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc         = 0;
  int   n_checks    = 0;
  int   n_fail      = 0;
  int   n_out       = 0;
  int   exp_err_cnt = 0;
  int   n_out0;

  always @(posedge clk_2) cyc++;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Drives a one-cycle in_valid from a negedge; accepted words go to the scoreboard.
  task automatic applyStimulus(input logic mode, input logic crc, input logic [W-1:0] msg,
                               input logic expect_accept, input logic [W-1:0] exp_msg,
                               input logic exp_err);
    exp_t e;
    in_valid   = 1'b1;
    in_mode    = mode;
    in_crc     = crc;
    in_message = msg;
    @(negedge clk_2);
    in_valid = 1'b0;
    if (expect_accept) begin
      e.msg   = exp_msg;
      e.err   = exp_err;
      e.t_acc = cyc;
      sb_q.push_back(e);
      checkOutput("busy_after_accept", busy, 1);
    end
  endtask

  task automatic waitOutValid(input int budget);
    int i;
    i = 0;
    while (out_valid !== 1'b1 && i < budget) begin
      @(negedge clk_2);
      i++;
    end
    checkOutput("out_valid_seen", out_valid, 1);
  endtask

  always @(negedge clk_2) begin
    if (rst === 1'b0 && out_valid === 1'b1) begin
      n_out++;
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        checkOutput("out_message", out_message, e.msg);
        checkOutput("out_err", out_err, e.err);
        checkOutput("latency", cyc - e.t_acc, W + 1);
        checkOutput("busy_low_at_out_valid", busy, 0);
`ifdef CRC_ENGINE_ERR_CNT_EN
        if (e.err && exp_err_cnt < 255) exp_err_cnt++;
        checkOutput("err_cnt", err_cnt, exp_err_cnt);
`endif
      end
    end
  end

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 60'h20,  60'h25,  1'b0};
    vecs[1]  = '{1'b0, 1'b1, 60'h100, 60'h107, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 60'h3F,  60'h25,  1'b0};
    vecs[3]  = '{1'b1, 1'b0, 60'h25,  60'h25,  1'b0};
    vecs[4]  = '{1'b1, 1'b0, 60'h24,  60'h24,  1'b1};
    vecs[5]  = '{1'b0, 1'b1, 60'h1FF, 60'h107, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 60'h107, 60'h107, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 60'h100, 60'h100, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 60'h800000000000000, 60'h800000000000016, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 60'h800000000000016, 60'h800000000000016, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 60'h3F,  60'h3F,  1'b1};

    rst        = 1'b1;
    in_valid   = 1'b0;
    in_mode    = 1'b0;
    in_crc     = 1'b0;
    in_message = '0;
    repeat (3) @(negedge clk_2);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_message", out_message, 0);
    checkOutput("reset_out_err", out_err, 0);
`ifdef CRC_ENGINE_ERR_CNT_EN
    checkOutput("reset_err_cnt", err_cnt, 0);
`endif
    rst = 1'b0;
    @(negedge clk_2);

    // Each new word is issued in the out_valid cycle of the previous one.
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].mode, vecs[i].crc, vecs[i].msg, 1'b1,
                    vecs[i].exp_msg, vecs[i].exp_err);
      waitOutValid(100);
    end
    @(negedge clk_2);

    $display("[TB] busy drop sequence");
    n_out0 = n_out;
    applyStimulus(1'b0, 1'b0, 60'h20, 1'b1, 60'h25, 1'b0);
    repeat (9) @(negedge clk_2);
    applyStimulus(1'b0, 1'b1, 60'h100, 1'b0, '0, 1'b0);
    waitOutValid(100);
    repeat (80) @(negedge clk_2);
    checkOutput("busy_drop_single_output", n_out - n_out0, 1);

    $display("[TB] reset mid-shift sequence");
    n_out0 = n_out;
    applyStimulus(1'b0, 1'b0, 60'h20, 1'b0, '0, 1'b0);
    repeat (29) @(negedge clk_2);
    rst         = 1'b1;
    exp_err_cnt = 0;
    @(negedge clk_2);
    rst = 1'b0;
    repeat (70) @(negedge clk_2);
    checkOutput("abort_no_output", n_out - n_out0, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_out_valid", out_valid, 0);
    checkOutput("abort_out_message", out_message, 0);
    checkOutput("abort_out_err", out_err, 0);
`ifdef CRC_ENGINE_ERR_CNT_EN
    checkOutput("abort_err_cnt", err_cnt, 0);
`endif
    applyStimulus(1'b0, 1'b0, 60'h20, 1'b1, 60'h25, 1'b0);
    waitOutValid(100);
    @(negedge clk_2);

`ifdef CRC_ENGINE_ERR_CNT_EN
    $display("[TB] error counter saturation sequence");
    for (int i = 0; i < 260; i++) begin
      applyStimulus(1'b1, 1'b0, 60'h24, 1'b1, 60'h24, 1'b1);
      waitOutValid(100);
    end
    repeat (3) @(negedge clk_2);
    checkOutput("err_cnt_saturated", err_cnt, 8'hFF);
`endif

    repeat (5) @(negedge clk_2);
    checkOutput("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/crc_engine.md
# crc_engine

Serial CRC generate/check engine in the clk_2 domain. Consumes one 60-bit message word with its mode and CRC-select bits after the word has been synchronised out of the clk_1 capture stage. Processes the word one bit per cycle through a selectable CRC-5 or CRC-8 divider. In generate mode it returns the message with the CRC appended in the low bits; in check mode it returns a pass/fail verdict.

## Interface
- pDATA_WIDTH, 60: message width in bits; must be greater than 8.
- clk_2  input  1  block clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  one-cycle strobe; in_mode, in_crc and in_message are valid in that cycle.
- in_mode  input  1  0 = generate, 1 = check.
- in_crc  input  1  0 = CRC-5, polynomial x^5+x^2+1; 1 = CRC-8, polynomial x^8+x^2+x+1.
- in_message  input  pDATA_WIDTH  message word, MSB first.
- busy  output  1  high while a word is in flight (state not IDLE).
- out_valid  output  1  one-cycle strobe; out_message and out_err are valid in that cycle.
- out_message  output  pDATA_WIDTH  generate mode: {in_message[W-1:n], crc[n-1:0]}, where n is 5 or 8. Check mode: in_message unchanged.
- out_err  output  1  check mode: 1 = non-zero remainder. Generate mode: always 0.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - When in_valid=1, load the shift register, latch mode and crc-select, clear the remainder and the bit counter, and go to SHIFT.
  - In generate mode, the low n bits of the loaded word are forced to 0 before shifting.
- SHIFT, one bit per cycle, MSB first:
  - fb = rem[n-1].
  - rem <= {rem[n-2:0], bit} ^ (fb ? poly_low : 0).
  - poly_low is 5'b00101 for CRC-5 and 8'h07 for CRC-8.
  - The register is 8 bits wide; for CRC-5 only rem[4:0] is used and rem[7:5] is held at 0.
- After bit index W-1 (the counter reaches W-1), go to DONE.
- DONE: register out_message and out_err, pulse out_valid for one cycle, return to IDLE.
- out_message and out_err hold their values until the next DONE.
- in_valid while busy=1 is ignored. The word is dropped and in-flight state is not disturbed.
- in_valid in the cycle out_valid is high is accepted, because the state is already IDLE. Back-to-back words are therefore supported.
- Reset mid-operation: all state clears immediately. The aborted word never produces out_valid.
- Reset values: busy=0, out_valid=0, out_message=0, out_err=0, state=IDLE, remainder=0, counter=0.

## Timing
- Input accepted at rising edge k, where in_valid=1 and state is IDLE.
- SHIFT occupies edges k+1 .. k+W.
- DONE is entered at edge k+W.
- out_valid=1 from edge k+W+1 to edge k+W+2. Latency is W+1 cycles (61 for W=60).
- busy is high from edge k to edge k+W+1. busy is low in the cycle out_valid is high.
- Throughput: one word per W+1 cycles.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- CRC_ENGINE_ERR_CNT_EN defined:
  - Adds output err_cnt (input to the bench, output of the block), 8 bits wide.
  - err_cnt increments at each out_valid with out_err=1.
  - err_cnt saturates at 8'hFF.
  - err_cnt resets to 0.
- CRC_ENGINE_ERR_CNT_EN undefined: the port and the counter logic are absent. All other behaviour is identical.

## Test plan
- Generate CRC-5: in_mode=0, in_crc=0, in_message=60'h20 -> out_message=60'h25, out_err=0, out_valid exactly 61 cycles after acceptance.
- Generate CRC-8 and low-bit masking:
  - in_mode=0, in_crc=1, in_message=60'h100 -> out_message=60'h107.
  - in_mode=0, in_crc=0, in_message=60'h3F -> out_message=60'h25.
- Check pass/fail, CRC-5:
  - in_mode=1, in_crc=0, in_message=60'h25 -> out_err=0.
  - Back-to-back, in_message=60'h24 -> out_err=1.
  - With CRC_ENGINE_ERR_CNT_EN defined, err_cnt=1 after the second word.
- Busy drop: pulse in_valid with 60'h100 while busy, 10 cycles after a valid accept -> only one out_valid; its result belongs to the first word.
- Reset mid-SHIFT: assert rst at cycle 30 of a word, release, wait 70 cycles -> no out_valid, all outputs 0. A following in_valid with 60'h20 (generate, CRC-5) -> 60'h25.
- Saturation (CRC_ENGINE_ERR_CNT_EN): 260 failing check words -> err_cnt holds 8'hFF.
